alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_pkg.sv | 20 ++
 rtl/alarm_timer.sv | 45 ++++
 rtl/alarm_ctrl.sv | 105 ++++++++++
 tb/tb_alarm_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
package alarm_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned PRESC_W = 4;
  localparam int unsigned SEC_W   = 9;

  localparam int unsigned DEF_CLK_PER_S      = 10;
  localparam int unsigned DEF_RING_TIMEOUT_S = 60;
  localparam int unsigned DEF_SNOOZE_S       = 300;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRinging,
    StSnooze
  } alarm_state_e;

endpackage

// File: rtl/alarm_timer.sv
// Prescaler plus seconds counter; both restart from zero when clr_i is high.
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_PER_S = DEF_CLK_PER_S
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  output logic [SEC_W-1:0] sec_o,
  output logic             tick_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;

  // tick_o flags the cycle on which the seconds count advances at the next edge.
  assign tick_o = (presc_q == PRESC_W'(CLK_PER_S - 1));
  assign sec_o  = sec_q;

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (clr_i) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (tick_o) begin
      presc_d = '0;
      sec_d   = sec_q + SEC_W'(1);
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm time registers, edge-detected minute match,
// and the idle/armed/ringing/snooze state machine with registered outputs.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_PER_S      = DEF_CLK_PER_S,
  parameter int unsigned RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
  parameter int unsigned SNOOZE_S       = DEF_SNOOZE_S
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HOUR_W-1:0] H_in,
  input  logic [MIN_W-1:0]  M_in,
  input  logic [HOUR_W-1:0] H_al,
  input  logic [MIN_W-1:0]  M_al,
  input  logic              LD_al,
  input  logic              AL_ON,
  input  logic              STOP_al,
  input  logic              SNOOZE,
  output logic              Alarm,
  output logic              Snoozing
);

  alarm_state_e      state_q, state_d;
  logic [HOUR_W-1:0] al_h_q, al_h_d;
  logic [MIN_W-1:0]  al_m_q, al_m_d;
  logic              match, match_q, trigger, ld_ok;
  logic              alarm_q, snoozing_q;
  logic              timer_clr, timer_tick;
  logic [SEC_W-1:0]  timer_sec;
  logic [SEC_W:0]    elapsed_next;

  alarm_timer #(
    .CLK_PER_S(CLK_PER_S)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (timer_clr),
    .sec_o  (timer_sec),
    .tick_o (timer_tick)
  );

  assign ld_ok   = LD_al && (H_al <= HOUR_W'(23)) && (M_al <= MIN_W'(59));
  assign match   = (H_in == al_h_q) && (M_in == al_m_q);
  assign trigger = match && !match_q;

  // Seconds value after this edge, so a timeout leaves the state exactly
  // N*CLK_PER_S cycles after entry.
  assign elapsed_next = {1'b0, timer_sec} + (SEC_W + 1)'(timer_tick);

  always_comb begin
    al_h_d = al_h_q;
    al_m_d = al_m_q;
    if (ld_ok) begin
      al_h_d = H_al;
      al_m_d = M_al;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!AL_ON) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StArmed;
        StArmed:   if (trigger) state_d = StRinging;
        StRinging: begin
          if (STOP_al) state_d = StArmed;
          else if (SNOOZE) state_d = StSnooze;
          else if (elapsed_next >= (SEC_W + 1)'(RING_TIMEOUT_S)) state_d = StArmed;
        end
        StSnooze: begin
          if (STOP_al || LD_al) state_d = StArmed;
          else if (elapsed_next >= (SEC_W + 1)'(SNOOZE_S)) state_d = StRinging;
        end
        default:   state_d = StIdle;
      endcase
    end
  end

  assign timer_clr = (state_d != state_q) && ((state_d == StRinging) || (state_d == StSnooze));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      alarm_q    <= 1'b0;
      snoozing_q <= 1'b0;
      al_h_q     <= '0;
      al_m_q     <= '0;
      match_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      alarm_q    <= (state_d == StRinging);
      snoozing_q <= (state_d == StSnooze);
      al_h_q     <= al_h_d;
      al_m_q     <= al_m_d;
      match_q    <= match;
    end
  end

  assign Alarm    = alarm_q;
  assign Snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with default timing parameters.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] H_in, H_al;
  logic [5:0] M_in, M_al;
  logic       LD_al, AL_ON, STOP_al, SNOOZE;
  logic       Alarm, Snoozing;

  int n_cmp = 0;
  int n_err = 0;

  alarm_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .H_in     (H_in),
    .M_in     (M_in),
    .H_al     (H_al),
    .M_al     (M_al),
    .LD_al    (LD_al),
    .AL_ON    (AL_ON),
    .STOP_al  (STOP_al),
    .SNOOZE   (SNOOZE),
    .Alarm    (Alarm),
    .Snoozing (Snoozing)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0; AL_ON = 1'b1; H_in = 5'd0; M_in = 6'd0; H_al = 5'd0; M_al = 6'd0;
    LD_al = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (Alarm !== 1'b0 || Snoozing !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: Alarm=%b Snoozing=%b required 0 0", Alarm, Snoozing);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Alarm !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++; $display("FAIL reset_no_trigger: Alarm rose=%b required 0", seen);
    end
    M_in = 6'd1; tick();
    M_in = 6'd0; tick();
    n_cmp++;
    if (Alarm !== 1'b1) begin
      n_err++; $display("FAIL reset_new_match: Alarm=%b required 1", Alarm);
    end
    STOP_al = 1'b1; tick(); STOP_al = 1'b0;
    n_cmp++;
    if (Alarm !== 1'b0) begin
      n_err++; $display("FAIL reset_stop: Alarm=%b required 0", Alarm);
    end
  endtask

  task automatic test_ring_timeout();
    int  cnt;
    bit  seen;
    H_al = 5'd7; M_al = 6'd30; LD_al = 1'b1; tick(); LD_al = 1'b0;
    H_in = 5'd7; M_in = 6'd29; tick(); tick();
    M_in = 6'd30;
    n_cmp++;
    if (Alarm !== 1'b0) begin
      n_err++; $display("FAIL ring_before_edge: Alarm=%b required 0", Alarm);
    end
    tick();
    n_cmp++;
    if (Alarm !== 1'b1) begin
      n_err++; $display("FAIL ring_start: Alarm=%b required 1", Alarm);
    end
    cnt = 1;
    for (int i = 0; i < 700 && Alarm === 1'b1; i++) begin
      tick();
      if (Alarm === 1'b1) cnt++;
    end
    n_cmp++;
    if (cnt != 600) begin
      n_err++; $display("FAIL ring_length: cycles=%0d required 600", cnt);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (Alarm !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++; $display("FAIL ring_no_retrigger: Alarm rose=%b required 0", seen);
    end
  endtask

  task automatic test_invalid_load();
    H_in = 5'd6; M_in = 6'd0; tick();
    H_al = 5'd24; M_al = 6'd10; LD_al = 1'b1; tick();
    H_al = 5'd23; M_al = 6'd60; tick(); LD_al = 1'b0;
    H_in = 5'd23; M_in = 6'd59; tick();
    M_in = 6'd60; tick(); tick();
    n_cmp++;
    if (Alarm !== 1'b0) begin
      n_err++; $display("FAIL load_23_60_ignored: Alarm=%b required 0", Alarm);
    end
    H_in = 5'd24; M_in = 6'd9; tick();
    M_in = 6'd10; tick(); tick();
    n_cmp++;
    if (Alarm !== 1'b0) begin
      n_err++; $display("FAIL load_24_10_ignored: Alarm=%b required 0", Alarm);
    end
    H_in = 5'd7; M_in = 6'd29; tick();
    M_in = 6'd30; tick();
    n_cmp++;
    if (Alarm !== 1'b1) begin
      n_err++; $display("FAIL load_kept_0730: Alarm=%b required 1", Alarm);
    end
    STOP_al = 1'b1; tick(); STOP_al = 1'b0;
  endtask

  task automatic test_stop_snooze_same();
    M_in = 6'd31; tick();
    M_in = 6'd30; tick();
    n_cmp++;
    if (Alarm !== 1'b1) begin
      n_err++; $display("FAIL both_ring: Alarm=%b required 1", Alarm);
    end
    STOP_al = 1'b1; SNOOZE = 1'b1; tick();
    STOP_al = 1'b0; SNOOZE = 1'b0;
    n_cmp++;
    if (Alarm !== 1'b0 || Snoozing !== 1'b0) begin
      n_err++; $display("FAIL both_stop_wins: Alarm=%b Snoozing=%b required 0 0", Alarm, Snoozing);
    end
    tick();
    M_in = 6'd31; tick();
    M_in = 6'd30; tick();
    n_cmp++;
    if (Alarm !== 1'b1) begin
      n_err++; $display("FAIL both_rearmed: Alarm=%b required 1", Alarm);
    end
  endtask

  task automatic test_snooze();
    int cnt;
    SNOOZE = 1'b1; tick();
    n_cmp++;
    if (Snoozing !== 1'b1 || Alarm !== 1'b0) begin
      n_err++; $display("FAIL snooze_enter: Alarm=%b Snoozing=%b required 0 1", Alarm, Snoozing);
    end
    cnt = 1;
    for (int i = 0; i < 3100 && Snoozing === 1'b1; i++) begin
      if (i == 20) SNOOZE = 1'b0;
      tick();
      if (Snoozing === 1'b1) cnt++;
    end
    SNOOZE = 1'b0;
    n_cmp++;
    if (cnt != 3000) begin
      n_err++; $display("FAIL snooze_length: cycles=%0d required 3000", cnt);
    end
    n_cmp++;
    if (Alarm !== 1'b1) begin
      n_err++; $display("FAIL snooze_rering: Alarm=%b required 1", Alarm);
    end
    SNOOZE = 1'b1; tick(); SNOOZE = 1'b0;
    repeat (50) tick();
    STOP_al = 1'b1; tick(); STOP_al = 1'b0;
    n_cmp++;
    if (Alarm !== 1'b0 || Snoozing !== 1'b0) begin
      n_err++; $display("FAIL snooze_stop: Alarm=%b Snoozing=%b required 0 0", Alarm, Snoozing);
    end
  endtask

  task automatic test_load_while_active();
    M_in = 6'd31; tick();
    M_in = 6'd30; tick();
    H_al = 5'd8; M_al = 6'd0; LD_al = 1'b1; tick(); LD_al = 1'b0;
    tick();
    n_cmp++;
    if (Alarm !== 1'b1) begin
      n_err++; $display("FAIL load_in_ring_stays: Alarm=%b required 1", Alarm);
    end
    SNOOZE = 1'b1; tick(); SNOOZE = 1'b0;
    H_al = 5'd9; M_al = 6'd0; LD_al = 1'b1; tick(); LD_al = 1'b0;
    n_cmp++;
    if (Alarm !== 1'b0 || Snoozing !== 1'b0) begin
      n_err++; $display("FAIL load_cancels_snooze: Alarm=%b Snoozing=%b required 0 0",
                        Alarm, Snoozing);
    end
    H_in = 5'd8; M_in = 6'd59; tick();
    H_in = 5'd9; M_in = 6'd0; tick();
    n_cmp++;
    if (Alarm !== 1'b1) begin
      n_err++; $display("FAIL load_new_time_0900: Alarm=%b required 1", Alarm);
    end
    STOP_al = 1'b1; tick(); STOP_al = 1'b0;
  endtask

  task automatic test_alarm_off_and_reset();
    H_in = 5'd8; tick();
    H_in = 5'd9; tick();
    AL_ON = 1'b0; tick();
    n_cmp++;
    if (Alarm !== 1'b0) begin
      n_err++; $display("FAIL off_drops_alarm: Alarm=%b required 0", Alarm);
    end
    AL_ON = 1'b1; tick();
    H_in = 5'd8; tick();
    H_in = 5'd9; tick();
    SNOOZE = 1'b1; tick(); SNOOZE = 1'b0;
    n_cmp++;
    if (Snoozing !== 1'b1) begin
      n_err++; $display("FAIL off_resnooze: Snoozing=%b required 1", Snoozing);
    end
    rst_n = 1'b0; tick();
    n_cmp++;
    if (Alarm !== 1'b0 || Snoozing !== 1'b0) begin
      n_err++; $display("FAIL reset_in_snooze: Alarm=%b Snoozing=%b required 0 0",
                        Alarm, Snoozing);
    end
    rst_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_invalid_load();
    test_stop_snooze_same();
    test_snooze();
    test_load_while_active();
    test_alarm_off_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
